// File: rtl/rd53_pixconf_pkg.sv
// Shared definitions for the pixel configuration latch sequencer: config byte layout,
// power-on default and FSM state encoding.
package rd53_pixconf_pkg;

  localparam int unsigned PIX_CONF_W = 8;

  // Config byte field positions: {sign, tdac[3:0], hitor_en, cal_en, hit_en}
  localparam int unsigned SIGN     = 7;
  localparam int unsigned TDAC_MSB = 6;
  localparam int unsigned TDAC_LSB = 3;
  localparam int unsigned HITOR_EN = 2;
  localparam int unsigned CAL_EN   = 1;
  localparam int unsigned HIT_EN   = 0;

  localparam logic [PIX_CONF_W-1:0] PIX_CONF_DEFAULT = 8'b0_1111_1_0_1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StRead
  } pix_state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pixel_conf_sequencer.sv
// Region-level writer/reader for the per-pixel transparent config latches: sequences
// setup/strobe/hold around PixWr and returns single-pixel readback bytes.
module pixel_conf_sequencer
  import rd53_pixconf_pkg::*;
#(
  parameter int unsigned NPIX      = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WR_CYC    = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned RD_CYC    = 2,
  localparam int unsigned AW       = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic                    Clk,
  input  logic                    Reset_b,
  input  logic                    CmdValid,
  output logic                    CmdReady,
  input  logic                    CmdWrite,
  input  logic                    CmdBcast,
  input  logic [AW-1:0]           CmdAddr,
  input  logic [PIX_CONF_W-1:0]   CmdData,
  output logic [PIX_CONF_W-1:0]   PixDataIn,
  output logic [NPIX-1:0]         PixWr,
  input  logic [NPIX*8-1:0]       PixDataOut,
  output logic                    RdValid,
  output logic [PIX_CONF_W-1:0]   RdData,
  output logic                    Busy
);

  localparam int unsigned MaxCyc = max4(SETUP_CYC, WR_CYC, HOLD_CYC, RD_CYC);
  localparam int unsigned CW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  pix_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [AW-1:0]         addr_q;
  logic                  bcast_q;
  logic [NPIX-1:0]       wr_mask;
  logic [PIX_CONF_W-1:0] rd_byte;

  // Out-of-range addresses match no pixel: no strobe on write, zero on read.
  always_comb begin
    wr_mask = '0;
    rd_byte = '0;
    for (int i = 0; i < NPIX; i++) begin
      if (bcast_q || (addr_q == AW'(i))) wr_mask[i] = 1'b1;
      if (addr_q == AW'(i)) rd_byte = PixDataOut[8*i +: 8];
    end
  end

  assign Busy = ~CmdReady;

  always_ff @(posedge Clk or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      bcast_q   <= 1'b0;
      CmdReady  <= 1'b1;
      PixDataIn <= '0;
      PixWr     <= '0;
      RdValid   <= 1'b0;
      RdData    <= '0;
    end else begin
      RdValid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (CmdValid) begin
            addr_q   <= CmdAddr;
            bcast_q  <= CmdBcast;
            CmdReady <= 1'b0;
            if (CmdWrite) begin
              PixDataIn <= CmdData;
              state_q   <= StSetup;
              cnt_q     <= CW'(SETUP_CYC - 1);
            end else begin
              state_q <= StRead;
              cnt_q   <= CW'(RD_CYC - 1);
            end
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            state_q <= StStrobe;
            cnt_q   <= CW'(WR_CYC - 1);
            PixWr   <= wr_mask;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStrobe: begin
          if (cnt_q == '0) begin
            state_q <= StHold;
            cnt_q   <= CW'(HOLD_CYC - 1);
            PixWr   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q  <= StIdle;
            CmdReady <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRead: begin
          // Sample on the last settle cycle; result and ready appear together.
          if (cnt_q == '0) begin
            state_q  <= StIdle;
            CmdReady <= 1'b1;
            RdValid  <= 1'b1;
            RdData   <= rd_byte;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          CmdReady <= 1'b1;
          PixWr    <= '0;
        end
      endcase
    end
  end

endmodule
